data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/mem_pkg.sv | 47 ++++
 rtl/data_mem_array.sv | 40 ++++
 rtl/data_mem_responder.sv | 149 ++++++++++++++
 tb/tb_data_mem_responder.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types for the data memory responder: FSM states, op encoding, error causes.
// Latency: n/a (types and a pure combinational request checker only).
// Backpressure: n/a.
package mem_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;   // wide enough for WAIT_CYCLES up to 15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_MISALIGN = 2'd1,
        ERR_RANGE    = 2'd2,
        ERR_BOTH_OPS = 2'd3
    } err_cause_t;

    // Classifies a request at accept time. Conflicting strobes take precedence,
    // then alignment, then range; any non-NONE result means no array access.
    function automatic err_cause_t check_req(
        input logic              rd,
        input logic              wr,
        input logic [WORD_W-1:0] a,
        input int                depth
    );
        err_cause_t cause;
        cause = ERR_NONE;
        if (rd && wr) begin
            cause = ERR_BOTH_OPS;
        end else if (a[1:0] != 2'b00) begin
            cause = ERR_MISALIGN;
        end else if ({2'b00, a[31:2]} >= $unsigned(depth)) begin
            cause = ERR_RANGE;
        end
        return cause;
    endfunction

endpackage

// File: rtl/data_mem_array.sv
// Word storage: single clock, one write port, one synchronous read port, no reset.
// Latency: read data appears on rd_dat the edge after re is sampled; holds while re is low.
// Backpressure: none; every enabled access completes on the sampling edge.
// Ports: clk; we/wr_idx/wr_dat write port; re/rd_idx read port; rd_dat registered read data.
module data_mem_array
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [WORD_W-1:0] wr_dat,
    input  logic              re,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [WORD_W-1:0] rd_dat
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];
    logic [WORD_W-1:0] rd_dat_q;
    logic [WORD_W-1:0] rd_dat_d;

    always_comb begin
        rd_dat_d = rd_dat_q;
        if (re) begin
            rd_dat_d = mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_idx] <= wr_dat;
        end
        rd_dat_q <= rd_dat_d;
    end

    assign rd_dat = rd_dat_q;

endmodule

// File: rtl/data_mem_responder.sv
// Wait-state data memory responder: accepts one read/write strobe, checks it, answers with a ready pulse.
// Latency: strobe accepted at edge N -> ready/err high in cycle WAIT_CYCLES+1 after N (sampled at edge N+1+WAIT_CYCLES).
// Backpressure: busy high while a request is in flight; strobes seen while busy are dropped, not queued.
// Ports: clk, rst (sync, active-high); memRead/memWrite/addr/wrData request; rdData, ready, err, busy response.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [WORD_W-1:0] addr,
    input  logic [WORD_W-1:0] wrData,
    output logic [WORD_W-1:0] rdData,
    output logic              ready,
    output logic              err,
    output logic              busy
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [WORD_W-1:0] wdat_q, wdat_d;
    op_t               op_q, op_d;
    err_cause_t        cause_q, cause_d;
    logic              rd_vld_q, rd_vld_d;

    logic              strobe;
    err_cause_t        live_cause;
    op_t               live_op;
    logic              enter_resp;
    logic [IDX_W-1:0]  req_idx;
    logic [WORD_W-1:0] req_wdat;
    op_t               req_op;
    err_cause_t        req_cause;
    logic              mem_we;
    logic              mem_re;
    logic [WORD_W-1:0] arr_rd_dat;

    always_comb begin
        strobe     = memRead | memWrite;
        live_cause = check_req(memRead, memWrite, addr, DEPTH_WORDS);
        live_op    = memWrite ? OP_WRITE : OP_READ;

        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdat_d     = wdat_q;
        op_d       = op_q;
        cause_d    = cause_q;
        enter_resp = 1'b0;

        // The array access happens on the edge entering RESP. With no wait
        // states that edge is the accept edge itself, so the live request is
        // used instead of the latches, which are only being loaded then.
        req_idx    = idx_q;
        req_wdat   = wdat_q;
        req_op     = op_q;
        req_cause  = cause_q;

        case (state_q)
            IDLE: begin
                if (strobe) begin
                    idx_d   = addr[IDX_W+1:2];
                    wdat_d  = wrData;
                    op_d    = live_op;
                    cause_d = live_cause;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                        req_idx    = addr[IDX_W+1:2];
                        req_wdat   = wrData;
                        req_op     = live_op;
                        req_cause  = live_cause;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset on the edge entering RESP must cancel the access.
        mem_we   = enter_resp && !rst && (req_cause == ERR_NONE) && (req_op == OP_WRITE);
        mem_re   = enter_resp && !rst && (req_cause == ERR_NONE) && (req_op == OP_READ);
        rd_vld_d = rd_vld_q | mem_re;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            wdat_q   <= '0;
            op_q     <= OP_READ;
            cause_q  <= ERR_NONE;
            rd_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wdat_q   <= wdat_d;
            op_q     <= op_d;
            cause_q  <= cause_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    data_mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk    (clk),
        .we     (mem_we),
        .wr_idx (req_idx),
        .wr_dat (req_wdat),
        .re     (mem_re),
        .rd_idx (req_idx),
        .rd_dat (arr_rd_dat)
    );

    // The array's read register is unresettable and only loads on valid reads,
    // so it already holds the last successful read; rd_vld_q masks it to zero
    // from reset until the first valid read.
    assign rdData = rd_vld_q ? arr_rd_dat : '0;
    assign busy   = (state_q != IDLE);
    assign ready  = (state_q == RESP);
    assign err    = (state_q == RESP) && (cause_q != ERR_NONE);

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    // WAIT_CYCLES=2 instance
    logic        memRead, memWrite;
    logic [31:0] addr, wrData, rdData;
    logic        ready, err, busy;
    // WAIT_CYCLES=0 instance
    logic        rd0, wr0;
    logic [31:0] addr0, wd0, rdat0;
    logic        rdy0, err0, busy0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .memRead  (memRead),
        .memWrite (memWrite),
        .addr     (addr),
        .wrData   (wrData),
        .rdData   (rdData),
        .ready    (ready),
        .err      (err),
        .busy     (busy)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk      (clk),
        .rst      (rst),
        .memRead  (rd0),
        .memWrite (wr0),
        .addr     (addr0),
        .wrData   (wd0),
        .rdData   (rdat0),
        .ready    (rdy0),
        .err      (err0),
        .busy     (busy0)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request on the WAIT_CYCLES=2 instance. Observes 8 cycles after the
    // accept edge (cycle k = k-th negedge after accept). Optionally strobes a
    // second read during the first wait cycle, which must be ignored.
    task automatic run_req(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, input logic inject,
                           output int lat, output int pulses, output logic e,
                           output logic b1);
        @(posedge clk); #1;
        memRead = rd; memWrite = wr; addr = a; wrData = d;
        @(posedge clk); #1;
        memRead = 1'b0; memWrite = 1'b0;
        lat = -1; pulses = 0; e = 1'b0; b1 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                b1 = busy;
                if (inject) begin
                    memRead = 1'b1; addr = 32'h0;
                end
            end
            if (k == 2) memRead = 1'b0;
            if (ready) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    e   = err;
                end
            end
        end
    endtask

    int   lat, pulses, npulse0;
    logic e, b1;

    initial begin
        rst = 1'b1;
        memRead = 1'b0; memWrite = 1'b0; addr = '0; wrData = '0;
        rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wd0 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_rdData", rdData, 32'h0);
        chk("reset_ready",  {31'b0, ready}, 32'd0);
        chk("reset_err",    {31'b0, err},   32'd0);
        chk("reset_busy",   {31'b0, busy},  32'd0);
        rst = 1'b0;

        // Write 0xDEADBEEF to 0x10
        run_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, lat, pulses, e, b1);
        chk("wr_latency", 32'(lat),    32'd3);
        chk("wr_pulses",  32'(pulses), 32'd1);
        chk("wr_err",     {31'b0, e},  32'd0);
        chk("wr_busy",    {31'b0, b1}, 32'd1);

        // Read it back
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, lat, pulses, e, b1);
        chk("rd_latency", 32'(lat),   32'd3);
        chk("rd_err",     {31'b0, e}, 32'd0);
        chk("rd_data",    rdData,     32'hDEADBEEF);

        // Misaligned read: error, rdData unchanged
        run_req(1'b1, 1'b0, 32'h13, 32'h0, 1'b0, lat, pulses, e, b1);
        chk("misalign_latency", 32'(lat),   32'd3);
        chk("misalign_err",     {31'b0, e}, 32'd1);
        chk("misalign_rdData",  rdData,     32'hDEADBEEF);

        // Word 0 known value, then out-of-range write that would alias to word 0
        run_req(1'b0, 1'b1, 32'h0, 32'h11111111, 1'b0, lat, pulses, e, b1);
        chk("wr0_err", {31'b0, e}, 32'd0);
        run_req(1'b0, 1'b1, 32'h400, 32'hCAFEF00D, 1'b0, lat, pulses, e, b1);
        chk("oor_err",     {31'b0, e},  32'd1);
        chk("oor_pulses",  32'(pulses), 32'd1);
        run_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, lat, pulses, e, b1);
        chk("oor_word0",   rdData,      32'h11111111);

        // Both strobes high
        run_req(1'b1, 1'b1, 32'h4, 32'h55555555, 1'b0, lat, pulses, e, b1);
        chk("both_err", {31'b0, e}, 32'd1);
        chk("both_rdData", rdData,  32'h11111111);

        // Second read strobed during WAIT is ignored
        run_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b1, lat, pulses, e, b1);
        chk("busy_pulses",  32'(pulses), 32'd1);
        chk("busy_latency", 32'(lat),    32'd3);
        chk("busy_rdData",  rdData,      32'hDEADBEEF);

        // Old value at 0x20, then reset on the edge entering RESP of a new write
        run_req(1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 1'b0, lat, pulses, e, b1);
        run_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, pulses, e, b1);
        chk("old20_rdData", rdData, 32'hA5A5A5A5);
        @(posedge clk); #1;
        memWrite = 1'b1; addr = 32'h20; wrData = 32'h12345678;
        @(posedge clk); #1;                 // accept edge N
        memWrite = 1'b0;
        @(posedge clk); #1;                 // edge N+1
        rst = 1'b1; memRead = 1'b1; addr = 32'h0;  // strobe during reset must drop
        @(posedge clk); #1;                 // edge N+2 would enter RESP
        rst = 1'b0; memRead = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("rst_busy", {31'b0, busy}, 32'd0);
            if (ready) pulses++;
        end
        chk("rst_no_ready", 32'(pulses), 32'd0);
        chk("rst_rdData",   rdData,      32'h0);
        run_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, pulses, e, b1);
        chk("rst_wr_suppressed", rdData, 32'hA5A5A5A5);

        // WAIT_CYCLES=0 instance: write, then reads held continuously
        @(posedge clk); #1;
        wr0 = 1'b1; addr0 = 32'h8; wd0 = 32'h0BADF00D;
        @(posedge clk); #1;                 // accept write at N
        wr0 = 1'b0; rd0 = 1'b1;
        @(negedge clk);
        chk("w0_wr_ready", {31'b0, rdy0},  32'd1);
        chk("w0_wr_err",   {31'b0, err0},  32'd0);
        @(negedge clk);
        chk("w0_idle_ready", {31'b0, rdy0},  32'd0);
        chk("w0_idle_busy",  {31'b0, busy0}, 32'd0);
        @(negedge clk);                     // read accepted at N+2
        chk("w0_rd_ready", {31'b0, rdy0}, 32'd1);
        chk("w0_rd_data",  rdat0,         32'h0BADF00D);
        npulse0 = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (rdy0) npulse0++;
        end
        chk("w0_b2b_pulses", 32'(npulse0), 32'd3);
        rd0 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
